mem_map_decoder: RTL and testbench
==================================

Name: mem_map_decoder

Overview:
Registered 4-to-16 one-hot address-region decoder for the processor's memory-mapped I/O and interrupt-control block. It turns a 4-bit region select S into a one-hot 16-bit strobe vector mapOut, one bit per mapped region. A software-loadable mask can disable individual regions. Outputs are registered so downstream peripheral enables are glitch-free.

Parameters:
SEL_W, 4, width of select input S.
OUT_W, 16, width of mapOut; must equal 2**SEL_W.
RESET_MASK, 16'hFFFF, value loaded into the region mask at reset (all regions enabled).

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RST_N  input  1  synchronous active-low reset, sampled on rising CLK.
S  input  SEL_W  region select (address high nibble).
en  input  1  decode enable; when high, the decode result is captured this cycle.
mask_we  input  1  mask write enable.
mask_in  input  OUT_W  new mask value, loaded when mask_we=1.
mapOut  output  OUT_W  registered one-hot region strobe, bit i = region i.
hit  output  1  registered; 1 when mapOut is nonzero.
sel_q  output  SEL_W  registered copy of the S value captured with the last decode.
mask_q  output  OUT_W  current mask register value.

Behaviour:
- Reset (RST_N=0 at a rising CLK edge):
  - mapOut=0, hit=0, sel_q=0, mask_q=RESET_MASK.
  - Reset has priority over en and mask_we. A reset mid-operation discards any decode or mask write in that cycle.
- Decode, at a rising edge with RST_N=1 and en=1:
  - mapOut <= (1 << S) & mask_q, where mask_q is the value before this edge.
  - sel_q <= S.
  - hit <= |((1 << S) & mask_q).
- When en=0:
  - mapOut and hit clear to 0 on the next edge; strobes are single-cycle per enabled cycle.
  - sel_q holds its value.
- Latency: exactly 1 cycle from S/en sampled to mapOut valid. There is no combinational path from S to any output.
- One-hot guarantee: mapOut has at most one bit set in every cycle, for all S in 0..15.
- Masked region: if mask_q[S]=0, the decode yields mapOut=0 and hit=0; sel_q still updates to S.
- Mask write, at a rising edge with RST_N=1 and mask_we=1:
  - mask_q <= mask_in.
  - If mask_we and en are both 1 in the same cycle, the decode uses the old mask. The new mask takes effect from the next cycle.
- Boundaries:
  - S=0 gives bit 0 and S=15 gives bit 15; there is no wrap or out-of-range case.
  - An X/Z on S is not required to be handled.
- Width rules:
  - Shift performed at OUT_W width.
  - Parameter check: an elaboration error is raised if OUT_W != 2**SEL_W.

Test Plan:
1. Hold RST_N=0 for 2 cycles with S=15, en=1 -> mapOut=16'h0000, hit=0, sel_q=0, mask_q=16'hFFFF. Release the reset.
2. en=1, S=15, one edge -> mapOut=16'h8000, hit=1, sel_q=15. Then S=0 -> 16'h0001. Sweep S=0..15 -> each cycle mapOut=1<<S, with exactly one bit set.
3. en=1, S=5, then en=0 for one cycle -> mapOut=16'h0020, then 16'h0000 and hit=0; sel_q stays 5.
4. mask_we=1, mask_in=16'h7FFF, one edge; then en=1, S=15 -> mapOut=16'h0000, hit=0, sel_q=15. Then S=14 -> mapOut=16'h4000.
5. Same cycle: mask_we=1 with mask_in=16'h0000, en=1, S=3 (old mask FFFF) -> mapOut=16'h0008. On the next cycle with S=3 -> mapOut=16'h0000.
6. Mid-stream reset: mapOut=16'h8000 and mask_q=16'h00FF, then assert RST_N=0 for one edge with en=1 and mask_we=1 -> mapOut=0, hit=0, sel_q=0, mask_q=16'hFFFF.

Source files
------------

// File: rtl/mem_map_decoder.sv
// mem_map_decoder
// ---------------------------------------------------------------------------
// Registered one-hot region decoder for the memory-mapped I/O and interrupt
// control block. A region select S is turned into a one-hot strobe vector,
// gated by a software-loadable region mask, and registered so that the
// downstream peripheral enables are glitch-free.
//
// Ports:
//   CLK      in   1      system clock, all state updates on the rising edge
//   RST_N    in   1      synchronous active-low reset
//   S        in   SEL_W  region select (address high nibble)
//   en       in   1      decode enable; decode result captured this cycle
//   mask_we  in   1      mask write enable
//   mask_in  in   OUT_W  new mask value, loaded when mask_we=1
//   mapOut   out  OUT_W  registered one-hot region strobe (bit i = region i)
//   hit      out  1      registered, high when mapOut is nonzero
//   sel_q    out  SEL_W  S value captured with the last decode
//   mask_q   out  OUT_W  current mask register value
// ---------------------------------------------------------------------------
module mem_map_decoder #(
  parameter int                SEL_W      = 4,
  parameter int                OUT_W      = 16,
  parameter logic [OUT_W-1:0]  RESET_MASK = 16'hFFFF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [SEL_W-1:0] S,
  input  logic             en,
  input  logic             mask_we,
  input  logic [OUT_W-1:0] mask_in,
  output logic [OUT_W-1:0] mapOut,
  output logic             hit,
  output logic [SEL_W-1:0] sel_q,
  output logic [OUT_W-1:0] mask_q
);

  // The decoder only makes sense when every select value maps to exactly
  // one strobe bit, so refuse to elaborate otherwise.
  generate
    if (OUT_W != 2**SEL_W) begin : gBadWidth
      $error("mem_map_decoder: OUT_W (%0d) must equal 2**SEL_W (%0d)", OUT_W, 2**SEL_W);
    end
  endgenerate

  logic [OUT_W-1:0] regionSel;
  logic [OUT_W-1:0] maskedSel;
  logic [OUT_W-1:0] mapOutReg;
  logic             hitReg;
  logic [SEL_W-1:0] selReg;
  logic [OUT_W-1:0] maskReg;

  // One comparator per region: each strobe bit is an independent equality
  // match, which guarantees the vector is one-hot for every S.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi = gi + 1) begin : gRegion
      assign regionSel[gi] = (S == SEL_W'(gi));
    end
  endgenerate

  // Decode uses the mask as it stands before this edge, so a mask write in
  // the same cycle only affects decodes from the following cycle onward.
  assign maskedSel = regionSel & maskReg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mapOutReg <= '0;
      hitReg    <= 1'b0;
      selReg    <= '0;
      maskReg   <= RESET_MASK;
    end else begin
      if (en) begin
        mapOutReg <= maskedSel;
        hitReg    <= |maskedSel;
        selReg    <= S;
      end else begin
        // Strobes are single-cycle: drop them whenever decode is idle.
        mapOutReg <= '0;
        hitReg    <= 1'b0;
      end
      if (mask_we) begin
        maskReg <= mask_in;
      end
    end
  end

  assign mapOut = mapOutReg;
  assign hit    = hitReg;
  assign sel_q  = selReg;
  assign mask_q = maskReg;

endmodule

// File: tb/tb_mem_map_decoder.sv
// tb_mem_map_decoder
// ---------------------------------------------------------------------------
// Directed self-checking bench for mem_map_decoder. Inputs are driven 1 time
// unit after a rising edge, outputs are sampled 1 time unit after the next
// rising edge. Every comparison goes through checkVal.
// ---------------------------------------------------------------------------
module tb_mem_map_decoder;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  S;
  logic        en;
  logic        mask_we;
  logic [15:0] mask_in;
  logic [15:0] mapOut;
  logic        hit;
  logic [3:0]  sel_q;
  logic [15:0] mask_q;

  int compareCount;
  int mismatchCount;

  mem_map_decoder #(
    .SEL_W      (4),
    .OUT_W      (16),
    .RESET_MASK (16'hFFFF)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .S       (S),
    .en      (en),
    .mask_we (mask_we),
    .mask_in (mask_in),
    .mapOut  (mapOut),
    .hit     (hit),
    .sel_q   (sel_q),
    .mask_q  (mask_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [15:0] expVec;
    compareCount  = 0;
    mismatchCount = 0;

    // 1. Reset held for two edges with decode requested.
    RST_N   = 1'b0;
    S       = 4'd15;
    en      = 1'b1;
    mask_we = 1'b0;
    mask_in = 16'h0000;
    step();
    step();
    checkVal("rst_mapOut", 32'(mapOut), 32'h0000);
    checkVal("rst_hit",    32'(hit),    32'h0);
    checkVal("rst_sel_q",  32'(sel_q),  32'h0);
    checkVal("rst_mask_q", 32'(mask_q), 32'hFFFF);
    RST_N = 1'b1;

    // 2. Boundary selects and a full sweep.
    S = 4'd15;
    step();
    checkVal("s15_mapOut", 32'(mapOut), 32'h8000);
    checkVal("s15_hit",    32'(hit),    32'h1);
    checkVal("s15_sel_q",  32'(sel_q),  32'd15);
    S = 4'd0;
    step();
    checkVal("s0_mapOut",  32'(mapOut), 32'h0001);
    for (int i = 0; i < 16; i++) begin
      S = 4'(i);
      step();
      expVec = 16'h0001 << i;
      checkVal($sformatf("sweep%0d_mapOut", i), 32'(mapOut), 32'(expVec));
      checkVal($sformatf("sweep%0d_ones", i), 32'($countones(mapOut)), 32'd1);
    end

    // 3. Strobe clears when en drops, sel_q holds.
    S = 4'd5;
    step();
    checkVal("s5_mapOut", 32'(mapOut), 32'h0020);
    en = 1'b0;
    S  = 4'd9;
    step();
    checkVal("idle_mapOut", 32'(mapOut), 32'h0000);
    checkVal("idle_hit",    32'(hit),    32'h0);
    checkVal("idle_sel_q",  32'(sel_q),  32'd5);

    // 4. Mask out region 15.
    mask_we = 1'b1;
    mask_in = 16'h7FFF;
    step();
    mask_we = 1'b0;
    checkVal("mask_load", 32'(mask_q), 32'h7FFF);
    en = 1'b1;
    S  = 4'd15;
    step();
    checkVal("masked_mapOut", 32'(mapOut), 32'h0000);
    checkVal("masked_hit",    32'(hit),    32'h0);
    checkVal("masked_sel_q",  32'(sel_q),  32'd15);
    S = 4'd14;
    step();
    checkVal("s14_mapOut", 32'(mapOut), 32'h4000);
    checkVal("s14_hit",    32'(hit),    32'h1);

    // 5. Same-cycle mask write uses the old mask for this decode.
    en      = 1'b0;
    mask_we = 1'b1;
    mask_in = 16'hFFFF;
    step();
    en      = 1'b1;
    S       = 4'd3;
    mask_in = 16'h0000;
    step();
    mask_we = 1'b0;
    checkVal("oldmask_mapOut", 32'(mapOut), 32'h0008);
    checkVal("oldmask_mask_q", 32'(mask_q), 32'h0000);
    step();
    checkVal("newmask_mapOut", 32'(mapOut), 32'h0000);
    checkVal("newmask_hit",    32'(hit),    32'h0);

    // 6. Mid-stream reset discards decode and mask write.
    en      = 1'b0;
    mask_we = 1'b1;
    mask_in = 16'hFFFF;
    step();
    en      = 1'b1;
    S       = 4'd15;
    mask_in = 16'h00FF;
    step();
    checkVal("pre_rst_mapOut", 32'(mapOut), 32'h8000);
    checkVal("pre_rst_mask_q", 32'(mask_q), 32'h00FF);
    RST_N   = 1'b0;
    S       = 4'd7;
    mask_in = 16'h1234;
    step();
    checkVal("midrst_mapOut", 32'(mapOut), 32'h0000);
    checkVal("midrst_hit",    32'(hit),    32'h0);
    checkVal("midrst_sel_q",  32'(sel_q),  32'h0);
    checkVal("midrst_mask_q", 32'(mask_q), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
